uart_tx_sched: RTL and testbench

//  Round-robin scheduler sharing one uart_tx serialiser among NREQ byte producers.

---
 rtl/uart_tx_sched.sv | 156 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that lets NREQ byte producers share one uart_tx serialiser.
// Each accepted byte gets a launch pulse, is held until done (or a watchdog abort), then a short gap.
module uart_tx_sched #(
  parameter int NREQ           = 4,
  parameter int BITS           = 8,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 i_wb_clk,
  input  logic                 i_wb_rst_n,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*BITS-1:0] i_req_data,
  output logic [NREQ-1:0]      o_req_ready,
  output logic                 o_tx_start,
  output logic [BITS-1:0]      o_tx_data,
  input  logic                 i_tx_done,
  output logic [NREQ-1:0]      o_grant,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW:0]    NREQ_W   = (PW+1)'(NREQ);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     GAP_LAST = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

  state_t          state_q,    state_d;
  logic [PW-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [WDW-1:0]  wd_cnt_q,   wd_cnt_d;
  logic [3:0]      gap_cnt_q,  gap_cnt_d;
  logic [BITS-1:0] tx_data_q,  tx_data_d;
  logic [NREQ-1:0] grant_q,    grant_d;
  logic            tx_start_q, tx_start_d;
  logic            busy_q,     busy_d;

  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] pick;
  logic [BITS-1:0] pick_data;
  logic            accept;
  logic            timeout_hit;

  // (base + off) modulo NREQ without a divider; both operands are < NREQ.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int unsigned off);
    logic [PW:0] sum;
    sum = {1'b0, base} + (PW+1)'(off);
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    return sum[PW-1:0];
  endfunction

  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_vld && i_req_valid[wrap_inc(rr_ptr_q, i)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_inc(rr_ptr_q, i);
      end
    end
    pick = '0;
    if (pick_vld) pick[pick_idx] = 1'b1;
    pick_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick[k]) pick_data = i_req_data[k*BITS +: BITS];
    end
  end

  assign accept      = (state_q == IDLE) && pick_vld;
  // Ready is combinational from valid, so it is gated off while reset is held.
  assign o_req_ready = (accept && i_wb_rst_n) ? pick : '0;
  // A done arriving on the last watchdog cycle takes precedence over the abort.
  assign timeout_hit = (state_q == WAIT) && !i_tx_done && (wd_cnt_q == WD_LAST);
  assign o_timeout   = timeout_hit;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wd_cnt_d   = wd_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    tx_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = LAUNCH;
          tx_data_d  = pick_data;
          grant_d    = pick;
          rr_ptr_d   = wrap_inc(pick_idx, 1);
          tx_start_d = 1'b1;
        end
      end
      LAUNCH: begin
        wd_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (i_tx_done || timeout_hit) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
            grant_d = '0;
          end else begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
          grant_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      wd_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wd_cnt_q   <= wd_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_grant    = grant_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: randomized requesters and a uart done responder, checked every
// cycle against a timestamp-based transaction model, plus directed literal expectations.
module tb_uart_tx_sched;
  localparam int NREQ = 4;
  localparam int BITS = 8;
  localparam int GAP  = 2;
  localparam int TO   = 64;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      drv_valid;
  logic [NREQ*BITS-1:0] drv_data;
  logic                 drv_done;
  logic [NREQ-1:0]      ready;
  logic                 start;
  logic [BITS-1:0]      tx_data;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic                 timeout;

  uart_tx_sched #(.NREQ(NREQ), .BITS(BITS), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_req_valid(drv_valid), .i_req_data(drv_data),
    .o_req_ready(ready), .o_tx_start(start), .o_tx_data(tx_data), .i_tx_done(drv_done),
    .o_grant(grant), .o_busy(busy), .o_timeout(timeout));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a byte is described by its owner, launch cycle and end cycle; the scheduler is
  // free again GAP+1 cycles after the byte ends.
  int t = 0;
  int m_owner = -1, m_start = 0, m_end = -1, m_free = 0, m_rr = 0, m_dly = 0;
  logic [BITS-1:0] m_data = '0;
  int mode = 1;
  bit stray_en = 1'b0, force_done = 1'b0;
  int acc_q[$];
  int to_cnt = 0, last_start_t = 0, last_to_t = 0;

  logic [NREQ-1:0] s_ready, s_grant;
  logic s_start, s_busy, s_timeout;
  logic [BITS-1:0] s_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  function automatic int pick_dly();
    int r;
    case (mode)
      1: return $urandom_range(40, 1);
      2: return 1000;
      3: return TO;
      default: begin
        r = $urandom_range(9);
        if (r == 0) return 1000;
        if (r == 1) return TO;
        if (r == 2) return TO - 1;
        return $urandom_range(50, 1);
      end
    endcase
  endfunction

  function automatic bit model_idle();
    return (m_owner < 0 || m_end >= 0) && (t >= m_free);
  endfunction

  task automatic model_cycle();
    logic [NREQ-1:0] er, eg;
    logic es, eb, et;
    bit idle, in_wait;
    int g;
    if (m_owner >= 0 && m_end >= 0 && t >= m_free) m_owner = -1;
    idle = (m_owner < 0) && (t >= m_free);
    g = -1;
    er = '0;
    if (idle)
      for (int i = 0; i < NREQ; i++)
        if (g < 0 && drv_valid[(m_rr + i) % NREQ]) g = (m_rr + i) % NREQ;
    if (g >= 0) er[g] = 1'b1;
    es = (m_owner >= 0) && (t == m_start);
    in_wait = (m_owner >= 0) && (m_end < 0) && (t > m_start);
    et = in_wait && !drv_done && (t == m_start + TO);
    eg = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
    eb = !idle;
    s_ready = ready; s_start = start; s_grant = grant;
    s_busy = busy; s_timeout = timeout; s_data = tx_data;
    chk("ready", s_ready, er);
    chk("start", s_start, es);
    chk("grant", s_grant, eg);
    chk("busy", s_busy, eb);
    chk("timeout", s_timeout, et);
    chk("data", s_data, m_data);
    if (s_start) last_start_t = t;
    if (s_timeout) begin to_cnt++; last_to_t = t; end
    if (in_wait && (drv_done || et)) begin
      m_end = t;
      m_free = t + 1 + GAP;
    end
    if (g >= 0) begin
      m_owner = g;
      m_data = drv_data[g*BITS +: BITS];
      m_start = t + 1;
      m_end = -1;
      m_rr = (g + 1) % NREQ;
      m_dly = pick_dly();
      acc_q.push_back(g);
    end
    t++;
  endtask

  task automatic tick();
    if ((m_owner >= 0) && (m_end < 0) && (t > m_start)) drv_done = (t == m_start + m_dly);
    else drv_done = force_done || (stray_en && $urandom_range(9) == 0);
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_inputs(input int prob, input bit allow_drop);
    for (int k = 0; k < NREQ; k++) begin
      if (drv_valid[k] && s_ready[k]) drv_valid[k] = 1'b0;
      else if (drv_valid[k] && allow_drop && $urandom_range(99) == 0) drv_valid[k] = 1'b0;
      if (!drv_valid[k] && $urandom_range(99) < prob) begin
        drv_valid[k] = 1'b1;
        drv_data[k*BITS +: BITS] = BITS'($urandom);
      end
    end
  endtask

  task automatic run_until_idle(input int max);
    int n;
    drv_valid = '0;
    for (n = 0; n < max; n++) begin
      if (model_idle()) break;
      tick();
    end
    if (n == max) chk("idle_bound", 32'(n), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, ready, '0);
    chk({tag, "_start"}, start, 1'b0);
    chk({tag, "_data"}, tx_data, '0);
    chk({tag, "_grant"}, grant, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_timeout"}, timeout, 1'b0);
  endtask

  initial begin
    int to_before;
    rst_n = 1'b0;
    drv_valid = '1;
    drv_data = '0;
    drv_done = 1'b0;
    s_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    drv_valid = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Single requester 2 with A5
    mode = 1;
    drv_valid = 4'b0100;
    drv_data[2*BITS +: BITS] = 8'hA5;
    tick();
    chk("t1_ready", s_ready, 4'b0100);
    drv_valid = '0;
    tick();
    chk("t1_start", s_start, 1'b1);
    chk("t1_grant", s_grant, 4'b0100);
    chk("t1_data", s_data, 8'hA5);
    run_until_idle(200);

    // All requesters continuously valid: strict rotation from rr_ptr=3
    stray_en = 1'b1;
    acc_q.delete();
    for (int n = 0; n < 1500 && acc_q.size() < 9; n++) begin
      gen_inputs(100, 1'b0);
      tick();
    end
    chk("t2_count", 32'(acc_q.size()), 32'd9);
    foreach (acc_q[i]) chk("t2_order", 32'(acc_q[i]), 32'((3 + i) % NREQ));
    run_until_idle(200);

    // Silent done: watchdog abort 64 cycles after start, then next requester served
    mode = 2;
    to_before = to_cnt;
    drv_valid = 4'b0001;
    drv_data[0 +: BITS] = 8'h3C;
    tick();
    drv_valid = '0;
    run_until_idle(200);
    chk("t3_to_count", 32'(to_cnt - to_before), 32'd1);
    chk("t3_to_delay", 32'(last_to_t - last_start_t), 32'd64);
    mode = 1;
    drv_valid = 4'b0011;
    tick();
    chk("t3_next", s_ready, 4'b0010);
    run_until_idle(200);

    // Done on the watchdog's last cycle: no abort
    mode = 3;
    to_before = to_cnt;
    drv_valid = 4'b0100;
    tick();
    drv_valid = '0;
    run_until_idle(200);
    chk("t4_no_timeout", 32'(to_cnt - to_before), 32'd0);

    // Stray done while idle and throughout a byte's launch and gap
    mode = 1;
    force_done = 1'b1;
    tick();
    chk("t5_idle_busy", s_busy, 1'b0);
    tick();
    chk("t5_idle_start", s_start, 1'b0);
    drv_valid = 4'b1000;
    tick();
    drv_valid = '0;
    run_until_idle(200);
    force_done = 1'b0;

    // Reset during WAIT, with all requesters valid
    mode = 2;
    drv_valid = 4'b1000;
    tick();
    drv_valid = '0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    drv_valid = '1;
    drv_done = 1'b0;
    #1 check_all_zero("rst_mid");
    @(posedge clk);
    #3 check_all_zero("rst_hold");
    rst_n = 1'b1;
    m_owner = -1; m_end = -1; m_free = 0; m_rr = 0; m_data = '0;
    mode = 1;
    tick();
    chk("t6_first", s_ready, 4'b0001);
    for (int n = 0; n < 100; n++) begin
      gen_inputs(0, 1'b0);
      tick();
    end
    run_until_idle(200);

    // Randomized traffic with mixed done behaviour
    mode = 0;
    for (int n = 0; n < 4000; n++) begin
      gen_inputs(30, 1'b1);
      tick();
    end
    run_until_idle(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
